ex_div: RTL and testbench
=========================

# ex_div

Iterative 32-bit integer divider in the EX stage, serving DIV.W/MOD.W/DIV.WU/MOD.WU. It latches operands from the ID/EX register outputs and produces one quotient bit per cycle by restoring division. While it runs, it drives `suspend` back into the IF/ID and ID/EX pipeline registers. When it finishes, it issues its own one-cycle register-file write-back request.

## Interface
- `DATA_W`, default 32: operand and result width. Only 32 is supported.
- `cpu_clk` in 1: core clock, rising-edge.
- `cpu_rst` in 1: synchronous, active-high reset.
- `valid_in` in 1: EX-stage instruction valid, driven by ID/EX `valid_out`.
- `start_in` in 1: the EX instruction is a divide op, decoded from `alu_op_out`.
- `op_in` in 2: 00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU.
- `rD1_in` in 32: dividend.
- `rD2_in` in 32: divisor.
- `wR_in` in 5: destination register.
- `flush` in 1: exception/kill request; aborts any divide in progress.
- `suspend` out 1: stall request to IF/ID and ID/EX.
- `done` out 1: result valid, one-cycle pulse.
- `wb_we` out 1: register-file write enable; equals `done`.
- `wb_wR` out 5: latched destination register.
- `wb_data` out 32: quotient or remainder.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE, accept:** when `valid_in & start_in & !flush`, the block latches the following, clears the 6-bit counter `cnt`, and moves to BUSY.
  - op, `wR_in`.
  - Signs: `sa = rD1[31] & signed`, `sb = rD2[31] & signed`.
  - Magnitudes `|rD1|` and `|rD2|`, using two's complement. For unsigned ops the raw values are used.
  - Quotient shift register `q` ← `|rD1|`; 33-bit partial remainder `r` ← 0.
- **BUSY, each cycle:**
  - `t = {r[31:0], q[31]}`.
  - If `t >= {1'b0, |d|}`: `r ← t - |d|` and `q ← {q[30:0], 1}`. Otherwise `r ← t` and `q ← {q[30:0], 0}`.
  - `cnt ← cnt+1`. After the 32nd iteration (`cnt == 31` at the edge) the state moves to DONE.
- **DONE:** `done = wb_we = 1`; `wb_data` holds the result. Next state is IDLE unconditionally. Any `start_in` seen in DONE is ignored.
- **Result selection:**
  - DIV: `sa^sb ? -q : q`.
  - MOD: `sa ? -r[31:0] : r[31:0]`.
  - The result is computed combinationally from the final `q`/`r` and registered into `wb_data` on the BUSY→DONE edge.
- **Divisor zero** (decided values, no trap):
  - Quotient = 0xFFFFFFFF for all ops, with sign correction suppressed.
  - Remainder = raw dividend `rD1`.
- **Signed overflow**, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This is the natural wrap; no special case.
- **`suspend`:**
  - Combinational: `(IDLE & valid_in & start_in & !flush) | BUSY`.
  - Low in DONE, so the next instruction enters EX in the cycle after DONE.
  - ID/EX bubbles `valid_out` while suspended. That is why the operands and `wR` are latched here.
- **`flush`:**
  - In BUSY: next state IDLE, no `done`, and `suspend` drops in the same cycle.
  - In DONE: no effect; the write-back completes.
- **Reset:**
  - State IDLE.
  - `suspend`, `done`, `wb_we` = 0.
  - `wb_data` = 0, `wb_wR` = 0, `cnt` = 0.
  - A reset during BUSY abandons the divide with no write-back.

## Timing
- Accept at cycle T, BUSY T+1..T+32, DONE at T+33, IDLE at T+34.
- `suspend` is high T..T+32 (33 cycles) and low at T+33.
- Latency from accept to `done`: 33 cycles, fixed and independent of operand values (no early-out).
- Back-to-back divides: the second is accepted at T+34 at the earliest. Throughput is one divide per 34 cycles.
- `wb_we`/`wb_wR`/`wb_data` are valid only in the DONE cycle. `wb_wR` and `wb_data` hold their values until the next DONE.

## Test plan
- **DIV.W:** 100 / 7 accepted at T → `suspend` high T..T+32; `done` at T+33 with `wb_data = 14` and the latched `wb_wR`.
- **Signed and unsigned corner values:**
  - MOD.W −7 (0xFFFFFFF9) % 2 → 0xFFFFFFFF.
  - DIV.W −7 / 2 → 0xFFFFFFFD.
  - DIV.WU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
- **Divide by zero and overflow:**
  - DIV.W 5 / 0 → 0xFFFFFFFF.
  - MOD.WU 5 / 0 → 5.
  - DIV.W 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - MOD.W with the same operands → 0.
- **Flush and reset:**
  - `flush` at T+10 → `suspend` low the same cycle, no `done`, back in IDLE at T+11.
  - `cpu_rst` at T+20 → all outputs 0 the next cycle.
- **Back-to-back:** a second divide is presented continuously from T+33. It is not accepted in DONE, is accepted at T+34, and gives `done` at T+67 with the correct result.
- **Non-divide op** (`start_in = 0`) or `valid_in = 0` with `start_in = 1` → `suspend` stays 0 and the state stays IDLE.

Source files
------------

// File: rtl/ex_div_if.sv
// EX-stage divider port bundle: operand/launch signals from ID/EX, stall and write-back back out.
interface ex_div_if #(
   parameter int unsigned DATA_W = 32
);
   logic              valid_in;
   logic              start_in;
   logic [1:0]        op_in;
   logic [DATA_W-1:0] rD1_in;
   logic [DATA_W-1:0] rD2_in;
   logic [4:0]        wR_in;
   logic              flush;
   logic              suspend;
   logic              done;
   logic              wb_we;
   logic [4:0]        wb_wR;
   logic [DATA_W-1:0] wb_data;

   // Pipeline side: presents the instruction, consumes stall and write-back.
   modport master (
      output valid_in, start_in, op_in, rD1_in, rD2_in, wR_in, flush,
      input  suspend, done, wb_we, wb_wR, wb_data
   );

   // Divider side.
   modport slave (
      input  valid_in, start_in, op_in, rD1_in, rD2_in, wR_in, flush,
      output suspend, done, wb_we, wb_wR, wb_data
   );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU; one quotient bit per cycle,
// stalls the front of the pipe while busy and issues its own one-cycle write-back.
module ex_div #(
   parameter int unsigned DATA_W = 32
) (
   input logic     cpu_clk,
   input logic     cpu_rst,
   ex_div_if.slave bus
);
   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]  cnt;
   logic [1:0]        op;
   logic [4:0]        wr;
   logic              sa, sb, dz;
   logic [DATA_W-1:0] d;
   logic [DATA_W-1:0] q;
   logic [DATA_W-1:0] r;
   logic              done_q;
   logic [DATA_W-1:0] wb_data_q;
   logic [4:0]        wb_wr_q;

   logic              accept_c;
   logic              finish_c;
   logic              suspend_c;
   logic              sgn_c;
   logic [DATA_W-1:0] abs_a_c, abs_b_c;
   logic [DATA_W:0]   t_c;
   logic              ge_c;
   logic [DATA_W-1:0] q_nxt_c, r_nxt_c;
   logic [DATA_W-1:0] result_c;

   assign accept_c = (state == IDLE) & bus.valid_in & bus.start_in & ~bus.flush;
   assign finish_c = (state == BUSY) & (cnt == LAST_CNT) & ~bus.flush;

   // Operand conditioning: signed ops divide magnitudes, sign fixed up at the end.
   always_comb begin
      sgn_c   = ~bus.op_in[1];
      abs_a_c = (sgn_c & bus.rD1_in[DATA_W-1]) ? DATA_W'(-bus.rD1_in) : bus.rD1_in;
      abs_b_c = (sgn_c & bus.rD2_in[DATA_W-1]) ? DATA_W'(-bus.rD2_in) : bus.rD2_in;
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      t_c     = {r, q[DATA_W-1]};
      ge_c    = (t_c >= {1'b0, d});
      r_nxt_c = ge_c ? DATA_W'(t_c - {1'b0, d}) : t_c[DATA_W-1:0];
      q_nxt_c = {q[DATA_W-2:0], ge_c};
   end

   // Final result from the last step; divide-by-zero quotient is all ones without sign fix.
   always_comb begin
      result_c = '0;
      if (op[0]) begin
         result_c = sa ? DATA_W'(-r_nxt_c) : r_nxt_c;
      end else if (dz) begin
         result_c = '1;
      end else begin
         result_c = (sa ^ sb) ? DATA_W'(-q_nxt_c) : q_nxt_c;
      end
   end

   // State register.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and the combinational stall request.
   always_comb begin
      state_nxt = state;
      suspend_c = 1'b0;
      case (state)
         IDLE: begin
            if (accept_c) begin
               state_nxt = BUSY;
               suspend_c = 1'b1;
            end
         end
         BUSY: begin
            suspend_c = ~bus.flush;
            if (bus.flush)             state_nxt = IDLE;
            else if (cnt == LAST_CNT)  state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch, iteration datapath and registered write-back.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         cnt       <= '0;
         op        <= '0;
         wr        <= '0;
         sa        <= 1'b0;
         sb        <= 1'b0;
         dz        <= 1'b0;
         d         <= '0;
         q         <= '0;
         r         <= '0;
         done_q    <= 1'b0;
         wb_data_q <= '0;
         wb_wr_q   <= '0;
      end else begin
         done_q <= finish_c;
         if (accept_c) begin
            cnt <= '0;
            op  <= bus.op_in;
            wr  <= bus.wR_in;
            sa  <= sgn_c & bus.rD1_in[DATA_W-1];
            sb  <= sgn_c & bus.rD2_in[DATA_W-1];
            dz  <= (bus.rD2_in == '0);
            d   <= abs_b_c;
            q   <= abs_a_c;
            r   <= '0;
         end else if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
            q   <= q_nxt_c;
            r   <= r_nxt_c;
         end
         if (finish_c) begin
            wb_data_q <= result_c;
            wb_wr_q   <= wr;
         end
      end
   end

   assign bus.suspend = suspend_c;
   assign bus.done    = done_q;
   assign bus.wb_we   = done_q;
   assign bus.wb_data = wb_data_q;
   assign bus.wb_wR   = wb_wr_q;
endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: scoreboard of expected write-backs plus timing checks.
module tb_ex_div;
   logic cpu_clk = 1'b0;
   logic cpu_rst;

   ex_div_if bus ();

   ex_div dut (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .bus     (bus)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct packed {
      logic [4:0]  wr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference model written from the instruction definitions.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int sa, sbv;
      if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
      if (!op[1]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[0] ? 32'd0 : 32'h8000_0000;
         sa  = a;
         sbv = b;
         return op[0] ? 32'(sa % sbv) : 32'(sa / sbv);
      end
      return op[0] ? (a % b) : (a / b);
   endfunction

   // Write-back monitor: every done must match the oldest expected result.
   always @(negedge cpu_clk) begin
      exp_t e;
      if (bus.done) begin
         chk("wb_we", 32'(bus.wb_we), 32'd1);
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("wb_data", bus.wb_data, e.data);
            chk("wb_wR", 32'(bus.wb_wR), 32'(e.wr));
         end
      end
   end

   // Present a divide in the current cycle (called just after a rising edge), then scramble inputs.
   task automatic start_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wr, input logic push, input logic [31:0] exp);
      bus.valid_in = 1'b1;
      bus.start_in = 1'b1;
      bus.op_in    = op;
      bus.rD1_in   = a;
      bus.rD2_in   = b;
      bus.wR_in    = wr;
      if (push) sb.push_back('{wr: wr, data: exp});
      @(negedge cpu_clk);
      chk("accept_suspend", 32'(bus.suspend), 32'd1);
      @(posedge cpu_clk);
      #1;
      bus.valid_in = 1'b0;
      bus.start_in = 1'b0;
      bus.op_in    = 2'($urandom);
      bus.rD1_in   = $urandom;
      bus.rD2_in   = $urandom;
      bus.wR_in    = 5'($urandom);
   endtask

   // Count cycles from accept to done; suspend must hold through BUSY and drop in DONE.
   task automatic wait_done(input string tag);
      int   lat    = 0;
      logic sus_ok = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge cpu_clk);
         lat++;
         if (bus.done) break;
         if (!bus.suspend) sus_ok = 1'b0;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd33);
      chk({tag, "_suspend_busy"}, 32'(sus_ok), 32'd1);
      chk({tag, "_suspend_done"}, 32'(bus.suspend), 32'd0);
   endtask

   task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wr, input logic [31:0] exp);
      @(posedge cpu_clk);
      #1;
      start_div(op, a, b, wr, 1'b1, exp);
      wait_done(tag);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_suspend"}, 32'(bus.suspend), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_wb_we"}, 32'(bus.wb_we), 32'd0);
      chk({tag, "_wb_data"}, bus.wb_data, 32'd0);
      chk({tag, "_wb_wR"}, 32'(bus.wb_wR), 32'd0);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   initial begin
      vec_t vecs[9];
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      vecs[0] = '{2'b00, 32'd100,         32'd7,         32'd14};
      vecs[1] = '{2'b01, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF};
      vecs[2] = '{2'b00, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD};
      vecs[3] = '{2'b10, 32'hFFFF_FFFF,   32'd2,         32'h7FFF_FFFF};
      vecs[4] = '{2'b00, 32'd5,           32'd0,         32'hFFFF_FFFF};
      vecs[5] = '{2'b11, 32'd5,           32'd0,         32'd5};
      vecs[6] = '{2'b00, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000};
      vecs[7] = '{2'b01, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0};
      vecs[8] = '{2'b01, 32'hFFFF_FFF9,   32'd0,         32'hFFFF_FFF9};

      cpu_rst      = 1'b1;
      bus.valid_in = 1'b0;
      bus.start_in = 1'b0;
      bus.op_in    = 2'b00;
      bus.rD1_in   = '0;
      bus.rD2_in   = '0;
      bus.wR_in    = '0;
      bus.flush    = 1'b0;
      repeat (3) @(posedge cpu_clk);
      @(negedge cpu_clk);
      check_zero_outputs("reset");
      @(posedge cpu_clk);
      #1;
      cpu_rst = 1'b0;

      // Directed corner values.
      for (int i = 0; i < 9; i++)
         run_div($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp);

      // Random operands against the model, mixing small and full-width divisors.
      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
         if (i == 3) ra = 32'h8000_0000 | ra;
         run_div($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom), model(rop, ra, rb));
      end

      // Non-divide op and invalid instruction must not start the divider.
      @(posedge cpu_clk);
      #1;
      bus.valid_in = 1'b1;
      bus.start_in = 1'b0;
      @(negedge cpu_clk);
      chk("nondiv_suspend", 32'(bus.suspend), 32'd0);
      @(posedge cpu_clk);
      #1;
      bus.valid_in = 1'b0;
      bus.start_in = 1'b1;
      @(negedge cpu_clk);
      chk("invalid_suspend", 32'(bus.suspend), 32'd0);
      @(posedge cpu_clk);
      #1;
      bus.start_in = 1'b0;
      run_div("after_idle", 2'b10, 32'd1000, 32'd3, 5'd9, 32'd333);

      // Flush at T+10: suspend drops at once, no write-back, next divide accepted at T+11.
      @(posedge cpu_clk);
      #1;
      start_div(2'b00, 32'd500, 32'd5, 5'd12, 1'b0, 32'd0);
      repeat (9) @(posedge cpu_clk);
      #1;
      bus.flush = 1'b1;
      #1;
      chk("flush_suspend", 32'(bus.suspend), 32'd0);
      @(posedge cpu_clk);
      #1;
      bus.flush = 1'b0;
      start_div(2'b11, 32'd77, 32'd10, 5'd13, 1'b1, 32'd7);
      wait_done("post_flush");

      // Reset at T+20 abandons the divide and clears every output.
      @(posedge cpu_clk);
      #1;
      start_div(2'b00, 32'd900, 32'd4, 5'd14, 1'b0, 32'd0);
      repeat (19) @(posedge cpu_clk);
      #1;
      cpu_rst = 1'b1;
      @(posedge cpu_clk);
      #1;
      cpu_rst = 1'b0;
      @(negedge cpu_clk);
      check_zero_outputs("midrst");
      repeat (40) @(posedge cpu_clk);

      // Back-to-back: second divide held from the DONE cycle, accepted only one cycle later.
      @(posedge cpu_clk);
      #1;
      start_div(2'b00, 32'd1000, 32'd10, 5'd3, 1'b1, 32'd100);
      wait_done("b2b_first");
      bus.valid_in = 1'b1;
      bus.start_in = 1'b1;
      bus.op_in    = 2'b01;
      bus.rD1_in   = 32'd1001;
      bus.rD2_in   = 32'd10;
      bus.wR_in    = 5'd4;
      #1;
      chk("b2b_done_suspend", 32'(bus.suspend), 32'd0);
      sb.push_back('{wr: 5'd4, data: 32'd1});
      @(negedge cpu_clk);
      chk("b2b_accept_suspend", 32'(bus.suspend), 32'd1);
      @(posedge cpu_clk);
      #1;
      bus.valid_in = 1'b0;
      bus.start_in = 1'b0;
      wait_done("b2b_second");

      repeat (3) @(posedge cpu_clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "timeout");
   end
endmodule
